// File: rtl/pc_redirect_ctrl.sv
// Purpose : fetch PC sequencer; arbitrates trap/EX/ID/static next-PC sources and latches redirects seen under stall.
// Latency : 1 cycle from inputs to pc_o; flush pulses are registered alongside the redirected pc_o.
// Backpressure: stall_i holds pc_o; a redirect arriving under stall is parked in a pending register until release.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   static_pc_i               predictor / sequential next PC
//   trap_vld_i/trap_pc_i      trap redirect (highest priority)
//   ex_redir_vld_i/_pc_i      EX mispredict / jump redirect
//   id_redir_vld_i/_pc_i      ID direct-jump redirect (lowest priority)
//   stall_i                   hold fetch PC
//   br_resolve_i/br_taken_i   conditional branch outcome for the confidence counter
//   pc_o, pc_valid_o          registered fetch PC and its validity
//   flush_if_o, flush_id_o    one-cycle stage kills accompanying an applied redirect
//   pend_o                    a redirect is parked waiting for stall release
//   pred_cnt_o                2-bit saturating branch-confidence counter
//   misalign_o                only with PC_ALIGN_CHECK_EN: applied target had non-zero bits [1:0]
//
// Build option: define PC_ALIGN_CHECK_EN to force redirect targets to 4-byte alignment
// and expose misalign_o.

module pc_redirect_ctrl #(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] START_PC = 64'h0000_0000_8000_0000,
   parameter logic [1:0]        CNT_INIT = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] static_pc_i,
   input  logic              trap_vld_i,
   input  logic [ADDR_W-1:0] trap_pc_i,
   input  logic              ex_redir_vld_i,
   input  logic [ADDR_W-1:0] ex_redir_pc_i,
   input  logic              id_redir_vld_i,
   input  logic [ADDR_W-1:0] id_redir_pc_i,
   input  logic              stall_i,
   input  logic              br_resolve_i,
   input  logic              br_taken_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              flush_if_o,
   output logic              flush_id_o,
   output logic              pend_o,
`ifdef PC_ALIGN_CHECK_EN
   output logic              misalign_o,
`endif
   output logic [1:0]        pred_cnt_o
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   // Source codes are ordered so that a numerically larger code wins.
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_ID   = 2'd1;
   localparam logic [1:0] SRC_EX   = 2'd2;
   localparam logic [1:0] SRC_TRAP = 2'd3;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pc_valid_q, pc_valid_d;
   logic              flush_if_q, flush_if_d;
   logic              flush_id_q, flush_id_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [1:0]        pend_src_q, pend_src_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              misalign_q, misalign_d;

   // Combinational arbitration results for this cycle.
   logic [1:0]        win_src;
   logic [ADDR_W-1:0] win_pc;
   logic [1:0]        apply_src;   // source of the redirect loaded into pc this cycle
   logic [ADDR_W-1:0] apply_pc;
   logic [ADDR_W-1:0] load_pc;     // apply_pc after optional alignment

   // Fixed-priority pick among the live redirect requests.
   always_comb begin
      win_src = SRC_NONE;
      win_pc  = static_pc_i;
      if (trap_vld_i) begin
         win_src = SRC_TRAP;
         win_pc  = trap_pc_i;
      end else if (ex_redir_vld_i) begin
         win_src = SRC_EX;
         win_pc  = ex_redir_pc_i;
      end else if (id_redir_vld_i) begin
         win_src = SRC_ID;
         win_pc  = id_redir_pc_i;
      end
   end

   // Next-state decision for PC, pending register and FSM.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      pend_src_d = pend_src_q;
      apply_src  = SRC_NONE;
      apply_pc   = pc_q;

      case (state_q)
         BOOT: begin
            // Inputs, redirects included, are deliberately ignored here.
            state_d = RUN;
         end
         RUN: begin
            if (!stall_i) begin
               if (win_src != SRC_NONE) begin
                  apply_src = win_src;
                  apply_pc  = win_pc;
               end else begin
                  pc_d = static_pc_i;
               end
            end else if (win_src != SRC_NONE) begin
               pend_pc_d  = win_pc;
               pend_src_d = win_src;
               state_d    = PEND;
            end
         end
         PEND: begin
            if (stall_i) begin
               // Only a strictly stronger source may displace the parked one.
               if (win_src > pend_src_q) begin
                  pend_pc_d  = win_pc;
                  pend_src_d = win_src;
               end
            end else begin
               // Release: static_pc_i is never used; the parked or a stronger live redirect wins.
               if (win_src > pend_src_q) begin
                  apply_src = win_src;
                  apply_pc  = win_pc;
               end else begin
                  apply_src = pend_src_q;
                  apply_pc  = pend_pc_q;
               end
               pend_src_d = SRC_NONE;
               state_d    = RUN;
            end
         end
         default: begin
            state_d    = BOOT;
            pend_src_d = SRC_NONE;
         end
      endcase

`ifdef PC_ALIGN_CHECK_EN
      load_pc    = {apply_pc[ADDR_W-1:2], 2'b00};
      misalign_d = (apply_src != SRC_NONE) && (apply_pc[1:0] != 2'b00);
`else
      load_pc    = apply_pc;
      misalign_d = 1'b0;
`endif

      if (apply_src != SRC_NONE) begin
         pc_d = load_pc;
      end

      // Trap and EX redirects (codes 2,3) also kill ID; an ID redirect only kills IF.
      flush_if_d = (apply_src != SRC_NONE);
      flush_id_d = apply_src[1];
      pend_d     = (state_d == PEND);
      pc_valid_d = 1'b1;
   end

   // Saturating confidence counter; frozen only while booting.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != BOOT) && br_resolve_i) begin
         if (br_taken_i) begin
            if (cnt_q != 2'b11) cnt_d = cnt_q + 2'b01;
         end else begin
            if (cnt_q != 2'b00) cnt_d = cnt_q - 2'b01;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= START_PC;
         pc_valid_q <= 1'b0;
         flush_if_q <= 1'b0;
         flush_id_q <= 1'b0;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         pend_src_q <= SRC_NONE;
         cnt_q      <= CNT_INIT;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         flush_if_q <= flush_if_d;
         flush_id_q <= flush_id_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         pend_src_q <= pend_src_d;
         cnt_q      <= cnt_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = pc_valid_q;
   assign flush_if_o = flush_if_q;
   assign flush_id_o = flush_id_q;
   assign pend_o     = pend_q;
   assign pred_cnt_o = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
   assign misalign_o = misalign_q;
`else
   // Without the alignment option the flag is always clear and has no port.
   logic unused_misalign;
   assign unused_misalign = misalign_q;
`endif

endmodule
